coreabc_ram_arbiter: RTL and testbench

Two-requester access controller for the 256x16 synchronous RAM used by the COREABC sequencer. It shares the RAM's single write/read port pair between two masters, such as the instruction sequencer and the host/APB debug path, using round-robin arbitration. It also owns a fill engine that initialises every word to a constant after reset or on command. It sits directly between the requesters and the RAM macro, and its RAM-side ports connect one-to-one to the RAM's WEN/REN/WADDR/RADDR/WD/RD.

---
 rtl/coreabc_ram_pkg.sv | 14 +
 rtl/coreabc_rr_arb2.sv | 24 ++
 rtl/coreabc_ram_arbiter.sv | 133 +++++++++++++
 tb/tb_coreabc_ram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/coreabc_ram_pkg.sv
// Shared sizing and state encoding for the COREABC RAM access controller.
package coreabc_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARB   = 2'd2
    } state_t;

endpackage

// File: rtl/coreabc_rr_arb2.sv
// Two-way round-robin grant logic; the last-grant pointer flop lives in the parent.
module coreabc_rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    // One-hot grant; on a tie the requester that did not win last time goes next.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        ptr_nxt = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : ptr);
    end

endmodule

// File: rtl/coreabc_ram_arbiter.sv
// Shares one 256x16 synchronous RAM port pair between two requesters and
// owns a fill engine that writes INIT_VALUE to every word.
module coreabc_ram_arbiter
    import coreabc_ram_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE     = 16'h0000,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              RWCLK,
    input  logic              RESET,
    input  logic              CLEAR,
    output logic              BUSY,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [DATA_W-1:0] WD1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    output logic              RAM_WEN,
    output logic              RAM_REN,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic [ADDR_W-1:0] RAM_RADDR,
    output logic [DATA_W-1:0] RAM_WD,
    input  logic [DATA_W-1:0] RAM_RD
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fill_cnt;
    logic              last_ptr;
    logic              ptr_nxt;
    logic              arb_en;
    logic [1:0]        gnt;
    logic              vld0_p1;
    logic              vld1_p1;

    // Grants are only possible in ARB, and a CLEAR pulse pre-empts any request.
    assign arb_en = (state == ST_ARB) && !CLEAR;

    coreabc_rr_arb2 u_rr (
        .req     ({REQ1, REQ0}),
        .en      (arb_en),
        .ptr     (last_ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign GNT0    = gnt[0];
    assign GNT1    = gnt[1];
    assign BUSY    = (state != ST_ARB);
    assign RDATA   = RAM_RD;
    assign RVALID0 = vld0_p1;
    assign RVALID1 = vld1_p1;

    // Next-state selection for the START/FILL/ARB controller.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: state_nxt = CLEAR_ON_RESET ? ST_FILL : ST_ARB;
            ST_FILL:  state_nxt = (fill_cnt == LAST_ADDR) ? ST_ARB : ST_FILL;
            ST_ARB:   state_nxt = CLEAR ? ST_FILL : ST_ARB;
            default:  state_nxt = ST_START;
        endcase
    end

    // RAM port steering: fill writes, granted accesses, otherwise idle at zero.
    always_comb begin
        RAM_WEN   = 1'b0;
        RAM_REN   = 1'b0;
        RAM_WADDR = '0;
        RAM_RADDR = '0;
        RAM_WD    = '0;
        if (state == ST_FILL) begin
            RAM_WEN   = 1'b1;
            RAM_WADDR = fill_cnt;
            RAM_WD    = INIT_VALUE;
        end else if (gnt[0]) begin
            if (WE0) begin
                RAM_WEN   = 1'b1;
                RAM_WADDR = ADDR0;
                RAM_WD    = WD0;
            end else begin
                RAM_REN   = 1'b1;
                RAM_RADDR = ADDR0;
            end
        end else if (gnt[1]) begin
            if (WE1) begin
                RAM_WEN   = 1'b1;
                RAM_WADDR = ADDR1;
                RAM_WD    = WD1;
            end else begin
                RAM_REN   = 1'b1;
                RAM_RADDR = ADDR1;
            end
        end
    end

    // Controller state, fill address counter and round-robin pointer.
    always_ff @(posedge RWCLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_START;
            fill_cnt <= '0;
            last_ptr <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_ptr <= ptr_nxt;
            if (state == ST_FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // ---- read grant -> RVALID stage (RAM returns data one cycle after REN) ----
    always_ff @(posedge RWCLK or negedge RESET) begin
        if (!RESET) begin
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            vld0_p1 <= gnt[0] && !WE0;
            vld1_p1 <= gnt[1] && !WE1;
        end
    end

endmodule

// File: tb/tb_coreabc_ram_arbiter.sv
// Directed scoreboard bench for coreabc_ram_arbiter with a behavioural RAM.
module tb_coreabc_ram_arbiter;

    localparam logic [15:0] INIT = 16'hA5A5;

    logic        RWCLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CLEAR = 1'b0;
    logic        BUSY;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic        WE0 = 1'b0, WE1 = 1'b0;
    logic [7:0]  ADDR0 = '0, ADDR1 = '0;
    logic [15:0] WD0 = '0, WD1 = '0;
    logic        GNT0, GNT1, RVALID0, RVALID1;
    logic [15:0] RDATA;
    logic        RAM_WEN, RAM_REN;
    logic [7:0]  RAM_WADDR, RAM_RADDR;
    logic [15:0] RAM_WD;
    logic [15:0] RAM_RD = '0;

    logic [15:0] mem [256];
    logic [15:0] exp_mem [256];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_last = 1;

    always #5 RWCLK = ~RWCLK;

    coreabc_ram_arbiter #(.INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)) dut (
        .RWCLK(RWCLK), .RESET(RESET), .CLEAR(CLEAR), .BUSY(BUSY),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WD0(WD0), .WD1(WD1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .RAM_WEN(RAM_WEN), .RAM_REN(RAM_REN),
        .RAM_WADDR(RAM_WADDR), .RAM_RADDR(RAM_RADDR), .RAM_WD(RAM_WD),
        .RAM_RD(RAM_RD)
    );

    // Behavioural 256x16 RAM with registered read.
    always @(posedge RWCLK) begin
        if (RAM_WEN) mem[RAM_WADDR] <= RAM_WD;
        if (RAM_REN) RAM_RD <= mem[RAM_RADDR];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-data scoreboard: pop on every RVALID pulse.
    always @(negedge RWCLK) begin
        if (RESET) begin
            if (RAM_WEN && RAM_REN) chk("wen_ren_excl", 1, 0);
            if (RVALID0) begin
                if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
                else chk("rdata0", {16'h0, RDATA}, {16'h0, q0.pop_front()});
            end
            if (RVALID1) begin
                if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
                else chk("rdata1", {16'h0, RDATA}, {16'h0, q1.pop_front()});
            end
        end
    end

    task automatic next_cycle();
        @(posedge RWCLK);
        #1;
    endtask

    // Single access by requester r; waits (bounded) for its grant then drops REQ.
    task automatic access(input int r, input bit we, input logic [7:0] a, input logic [15:0] d);
        bit got = 0;
        if (r == 0) begin REQ0 = 1; WE0 = we; ADDR0 = a; WD0 = d; end
        else        begin REQ1 = 1; WE1 = we; ADDR1 = a; WD1 = d; end
        for (int i = 0; i < 20; i++) begin
            @(negedge RWCLK);
            if ((r == 0) ? GNT0 : GNT1) begin
                got = 1;
                exp_last = r;
                if (we) exp_mem[a] = d;
                else if (r == 0) q0.push_back(exp_mem[a]);
                else q1.push_back(exp_mem[a]);
                break;
            end
            next_cycle();
        end
        chk("grant_seen", {31'h0, got}, 1);
        next_cycle();
        if (r == 0) REQ0 = 0; else REQ1 = 0;
    endtask

    initial begin
        int n;
        bit ok;
        for (int i = 0; i < 256; i++) exp_mem[i] = INIT;

        // Reset state
        #3;
        chk("rst_busy", {31'h0, BUSY}, 1);
        chk("rst_gnt", {30'h0, GNT1, GNT0}, 0);
        chk("rst_rvalid", {30'h0, RVALID1, RVALID0}, 0);
        chk("rst_strobes", {30'h0, RAM_WEN, RAM_REN}, 0);
        chk("rst_addr", {8'h0, RAM_WADDR, RAM_RADDR, 8'h0}, 0);
        chk("rst_wd", {16'h0, RAM_WD}, 0);

        // Fill after reset release
        repeat (2) @(posedge RWCLK);
        #1 RESET = 1;
        n = 0;
        ok = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge RWCLK);
            if (!BUSY) break;
            if (n == 0) chk("start_no_wen", {31'h0, RAM_WEN}, 0);
            else if (!RAM_WEN || RAM_WADDR !== 8'(n - 1) || RAM_WD !== INIT) ok = 0;
            n++;
        end
        chk("fill_seq", {31'h0, ok}, 1);
        chk("busy_cycles_reset", n, 257);
        next_cycle();

        // Fill contents
        access(0, 0, 8'h00, 16'h0);
        access(1, 0, 8'h80, 16'h0);
        access(0, 0, 8'hFF, 16'h0);

        // Write then read same address
        access(0, 1, 8'h10, 16'h1234);
        access(0, 0, 8'h10, 16'h0);
        @(negedge RWCLK);
        chk("rvalid0_pulse", {31'h0, RVALID0}, 1);
        chk("rvalid1_quiet", {31'h0, RVALID1}, 0);
        next_cycle();
        @(negedge RWCLK);
        chk("rvalid0_single", {31'h0, RVALID0}, 0);
        next_cycle();

        // Both requesters held: alternating grants
        REQ0 = 1; WE0 = 0; ADDR0 = 8'h01;
        REQ1 = 1; WE1 = 0; ADDR1 = 8'h02;
        exp_mem[1] = INIT; exp_mem[2] = INIT;
        for (int i = 0; i < 6; i++) begin
            int g;
            @(negedge RWCLK);
            g = (exp_last == 1) ? 0 : 1;
            chk("alt_gnt", {30'h0, GNT1, GNT0}, (g == 0) ? 32'h1 : 32'h2);
            if (g == 0) q0.push_back(exp_mem[1]); else q1.push_back(exp_mem[2]);
            exp_last = g;
            next_cycle();
        end
        REQ0 = 0; REQ1 = 0;
        repeat (2) next_cycle();

        // Write a word so the clear is observable, then read granted just before CLEAR
        access(1, 1, 8'h02, 16'hBEEF);
        access(0, 0, 8'h02, 16'h0);
        CLEAR = 1; REQ1 = 1; WE1 = 0; ADDR1 = 8'h02;
        @(negedge RWCLK);
        chk("clear_gnt1", {31'h0, GNT1}, 0);
        chk("clear_busy_same", {31'h0, BUSY}, 0);
        next_cycle();
        CLEAR = 0;
        for (int i = 0; i < 256; i++) exp_mem[i] = INIT;
        n = 0;
        ok = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge RWCLK);
            if (!BUSY) break;
            if (GNT1 || GNT0) ok = 0;
            n++;
        end
        chk("no_gnt_in_fill", {31'h0, ok}, 1);
        chk("busy_cycles_clear", n, 256);
        chk("gnt1_after_fill", {31'h0, GNT1}, 1);
        if (GNT1) begin q1.push_back(exp_mem[2]); exp_last = 1; end
        next_cycle();
        REQ1 = 0;
        repeat (2) next_cycle();

        // Reset mid-fill
        CLEAR = 1;
        next_cycle();
        CLEAR = 0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge RWCLK);
            if (RAM_WEN && RAM_WADDR == 8'h40) begin ok = 1; break; end
        end
        chk("reach_addr40", {31'h0, ok}, 1);
        #2 RESET = 0;
        #1;
        chk("async_busy", {31'h0, BUSY}, 1);
        chk("async_strobes", {30'h0, RAM_WEN, RAM_REN}, 0);
        chk("async_waddr", {24'h0, RAM_WADDR}, 0);
        chk("async_gnt_rv", {28'h0, GNT1, GNT0, RVALID1, RVALID0}, 0);
        next_cycle();
        RESET = 1;
        @(negedge RWCLK);
        chk("restart_start", {30'h0, BUSY, RAM_WEN}, 32'h2);
        @(negedge RWCLK);
        chk("restart_addr0", {23'h0, RAM_WEN, RAM_WADDR}, 32'h100);
        @(negedge RWCLK);
        chk("restart_addr1", {23'h0, RAM_WEN, RAM_WADDR}, 32'h101);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge RWCLK);
            if (!BUSY) begin ok = 1; break; end
        end
        chk("refill_done", {31'h0, ok}, 1);
        exp_last = 1;
        next_cycle();
        access(0, 0, 8'h40, 16'h0);
        repeat (3) next_cycle();
        chk("sb_empty", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
